// File: rtl/sqrt_round_pack.sv
// Output stage of the pipelined square-root core: holds sideband tags,
// rounds the root to nearest-even, packs IEEE-754 and buffers results.
module sqrt_round_pack #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic             iss_sign,
    input  logic [EW-1:0]    iss_exp,
    input  logic [1:0]       iss_special,
    input  logic [MW+2:0]    core_out,
    input  logic             core_sticky,
    input  logic             core_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   out_result,
    output logic             out_inexact,
    output logic             err_underflow,
    output logic             err_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = EW + 3;
    localparam int OW = EW + MW + 2;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW:0]    r_inflight;
    logic [TW-1:0]  r_tag [DEPTH];
    logic [AW-1:0]  r_twr;
    logic [AW-1:0]  r_trd;
    logic [AW:0]    r_tcnt;
    logic [OW-1:0]  r_obuf [DEPTH];
    logic [AW-1:0]  r_owr;
    logic [AW-1:0]  r_ord;
    logic [AW:0]    r_ocnt;
    logic           r_underflow;
    logic           r_overrun;

    logic           w_iss;
    logic           w_tempty;
    logic           w_tpush;
    logic           w_tpop;
    logic           w_pop;
    logic           w_drop;
    logic           w_owr;
    logic           w_dec;
    logic           w_hsign;
    logic [EW-1:0]  w_hexp;
    logic [1:0]     w_hspec;
    logic           w_g;
    logic           w_s;
    logic           w_inc;
    logic [MW+1:0]  w_mant;
    logic           w_carry;
    logic [EW:0]    w_exp;
    logic           w_ovf;
    logic [EW+MW:0] w_res;
    logic           w_inx;

    assign iss_ready = r_inflight < FULL;
    assign w_iss     = iss_valid & iss_ready;
    assign w_tempty  = r_tcnt == '0;
    assign w_tpop    = core_done & ~w_tempty;
    assign w_tpush   = w_iss & ((r_tcnt != FULL) | w_tpop);

    assign out_valid = r_ocnt != '0;
    assign w_pop     = out_valid & out_ready;
    assign w_drop    = w_tpop & (r_ocnt == FULL) & ~w_pop;
    assign w_owr     = w_tpop & ~w_drop;
    // A dropped result still returns its credit so issue cannot deadlock.
    assign w_dec     = w_pop | w_drop;

    assign {out_inexact, out_result} = r_obuf[r_ord];
    assign err_underflow = r_underflow;
    assign err_overrun   = r_overrun;

    assign {w_hsign, w_hexp, w_hspec} = r_tag[r_trd];

    assign w_g     = core_out[1];
    assign w_s     = core_out[0] | core_sticky;
    assign w_inc   = w_g & (w_s | core_out[2]);
    assign w_mant  = {1'b0, core_out[MW+2:2]} + {{(MW+1){1'b0}}, w_inc};
    assign w_carry = w_mant[MW+1];
    assign w_exp   = {1'b0, w_hexp} + {{EW{1'b0}}, w_carry};
    assign w_ovf   = w_exp >= {1'b0, {EW{1'b1}}};

    always_comb begin
        w_res = '0;
        w_inx = 1'b0;
        case (w_hspec)
            2'b00: begin
                w_inx = core_out[1] | core_out[0] | core_sticky;
                if (w_ovf)
                    w_res = {1'b0, {EW{1'b1}}, {MW{1'b0}}};
                else if (w_carry)
                    w_res = {1'b0, w_exp[EW-1:0], {MW{1'b0}}};
                else
                    w_res = {1'b0, w_exp[EW-1:0], w_mant[MW-1:0]};
            end
            2'b01: w_res = {w_hsign, {(EW+MW){1'b0}}};
            2'b10: w_res = {1'b0, {EW{1'b1}}, {MW{1'b0}}};
            default: w_res = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tpush)
            r_tag[r_twr] <= {iss_sign, iss_exp, iss_special};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight  <= '0;
            r_twr       <= '0;
            r_trd       <= '0;
            r_tcnt      <= '0;
            r_owr       <= '0;
            r_ord       <= '0;
            r_ocnt      <= '0;
            r_underflow <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_obuf[i] <= '0;
        end else begin
            case ({w_iss, w_dec})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (w_tpush)
                r_twr <= r_twr + 1'b1;
            if (w_tpop)
                r_trd <= r_trd + 1'b1;
            case ({w_tpush, w_tpop})
                2'b10:   r_tcnt <= r_tcnt + 1'b1;
                2'b01:   r_tcnt <= r_tcnt - 1'b1;
                default: r_tcnt <= r_tcnt;
            endcase
            if (w_owr) begin
                r_obuf[r_owr] <= {w_inx, w_res};
                r_owr         <= r_owr + 1'b1;
            end
            if (w_pop)
                r_ord <= r_ord + 1'b1;
            case ({w_owr, w_pop})
                2'b10:   r_ocnt <= r_ocnt + 1'b1;
                2'b01:   r_ocnt <= r_ocnt - 1'b1;
                default: r_ocnt <= r_ocnt;
            endcase
            if (core_done & w_tempty)
                r_underflow <= 1'b1;
            if (w_drop)
                r_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sqrt_round_pack.sv
// Bench for sqrt_round_pack: directed corner cases plus a randomized
// stream scored against an arithmetic rounding model.
module tb_sqrt_round_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic        iss_sign = 1'b0;
    logic [7:0]  iss_exp = '0;
    logic [1:0]  iss_special = '0;
    logic [25:0] core_out = '0;
    logic        core_sticky = 1'b0;
    logic        core_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_inexact;
    logic        err_underflow;
    logic        err_overrun;

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        bit       s;
        bit [7:0] e;
        bit [1:0] sp;
    } tag_t;

    sqrt_round_pack #(.EW(8), .MW(23), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_sign(iss_sign), .iss_exp(iss_exp), .iss_special(iss_special),
        .core_out(core_out), .core_sticky(core_sticky), .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_inexact(out_inexact),
        .err_underflow(err_underflow), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Returns {inexact, packed word}, rounding by comparing the discarded tail to one half.
    function automatic logic [32:0] ref_pack(bit s, bit [7:0] e, bit [1:0] sp,
                                             bit [25:0] co, bit st);
        int unsigned m;
        int unsigned tail;
        int unsigned ee;
        bit          up;
        bit          inx;
        logic [32:0] r;
        if (sp == 2'd1) return {1'b0, s, 31'b0};
        if (sp == 2'd2) return {1'b0, 32'h7F800000};
        if (sp == 2'd3) return {1'b0, 32'h7FC00000};
        m    = int'(co) / 4;
        tail = (int'(co) % 4) * 2 + int'(st);
        up   = (tail > 4) || (tail == 4 && (m % 2) == 1);
        m    = m + int'(up);
        ee   = e;
        if (m == (1 << 24)) begin
            m  = m / 2;
            ee = ee + 1;
        end
        inx = tail != 0;
        if (ee >= 255) return {inx, 32'h7F800000};
        r = {inx, 1'b0, ee[7:0], m[22:0]};
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iss_valid = 1'b0;
        core_done = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_op(input bit s, input bit [7:0] e, input bit [1:0] sp,
                          input bit [25:0] co, input bit st,
                          output logic [31:0] res, output logic inx,
                          output logic lat_ok);
        iss_valid = 1'b1;
        iss_sign = s;
        iss_exp = e;
        iss_special = sp;
        cyc();
        iss_valid = 1'b0;
        core_done = 1'b1;
        core_out = co;
        core_sticky = st;
        lat_ok = !out_valid;
        cyc();
        core_done = 1'b0;
        lat_ok = lat_ok && out_valid;
        res = out_result;
        inx = out_inexact;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nchk++;
        if ({out_valid, out_result, out_inexact, err_underflow, err_overrun} !== 36'd0) begin
            nerr++;
            $display("FAIL reset_outputs got v=%b r=%h i=%b u=%b o=%b exp all 0",
                     out_valid, out_result, out_inexact, err_underflow, err_overrun);
        end
        nchk++;
        if (iss_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_iss_ready got=%b exp=1", iss_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        logic        x;
        logic        lat;
        run_op(0, 8'h7F, 2'd0, 26'h2000000, 0, r, x, lat);
        nchk++;
        if (r !== 32'h3F800000 || x !== 1'b0) begin
            nerr++;
            $display("FAIL t1_one got=%h/%b exp=3f800000/0", r, x);
        end
        nchk++;
        if (lat !== 1'b1) begin
            nerr++;
            $display("FAIL t1_latency got=%b exp=1", lat);
        end
        nchk++;
        if (out_valid !== 1'b0 || iss_ready !== 1'b1) begin
            nerr++;
            $display("FAIL t1_drained got v=%b rdy=%b exp v=0 rdy=1", out_valid, iss_ready);
        end
    endtask

    task automatic test_round_tie();
        logic [31:0] r;
        logic        x;
        logic        lat;
        run_op(0, 8'h7F, 2'd0, 26'h2000002, 0, r, x, lat);
        nchk++;
        if (r !== 32'h3F800000 || x !== 1'b1) begin
            nerr++;
            $display("FAIL t2_tie_even got=%h/%b exp=3f800000/1", r, x);
        end
        run_op(0, 8'h7F, 2'd0, 26'h2000006, 0, r, x, lat);
        nchk++;
        if (r !== 32'h3F800002 || x !== 1'b1) begin
            nerr++;
            $display("FAIL t2_tie_odd got=%h/%b exp=3f800002/1", r, x);
        end
        run_op(0, 8'h7F, 2'd0, 26'h2000002, 1, r, x, lat);
        nchk++;
        if (r !== 32'h3F800001 || x !== 1'b1) begin
            nerr++;
            $display("FAIL t2_above_half got=%h/%b exp=3f800001/1", r, x);
        end
        run_op(1, 8'h7F, 2'd0, 26'h2000001, 0, r, x, lat);
        nchk++;
        if (r !== 32'h3F800000 || x !== 1'b1) begin
            nerr++;
            $display("FAIL t2_below_half got=%h/%b exp=3f800000/1", r, x);
        end
    endtask

    task automatic test_carry();
        logic [31:0] r;
        logic        x;
        logic        lat;
        run_op(0, 8'h80, 2'd0, 26'h3FFFFFF, 0, r, x, lat);
        nchk++;
        if (r !== 32'h40800000 || x !== 1'b1) begin
            nerr++;
            $display("FAIL t3_carry got=%h/%b exp=40800000/1", r, x);
        end
        run_op(0, 8'hFE, 2'd0, 26'h3FFFFFF, 0, r, x, lat);
        nchk++;
        if (r !== 32'h7F800000 || x !== 1'b1) begin
            nerr++;
            $display("FAIL t3_carry_inf got=%h/%b exp=7f800000/1", r, x);
        end
    endtask

    task automatic test_specials();
        logic [31:0] want [3];
        want[0] = 32'h80000000;
        want[1] = 32'h7F800000;
        want[2] = 32'h7FC00000;
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1;
            iss_sign = 1'b1;
            iss_exp = 8'h55;
            iss_special = 2'(i + 1);
            cyc();
        end
        iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_done = 1'b1;
            core_out = 26'h3FFFFFF;
            core_sticky = 1'b1;
            cyc();
        end
        core_done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (out_valid !== 1'b1 || out_result !== want[i] || out_inexact !== 1'b0) begin
                nerr++;
                $display("FAIL t4_special%0d got v=%b %h/%b exp v=1 %h/0",
                         i, out_valid, out_result, out_inexact, want[i]);
            end
            cyc();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_credits();
        logic [32:0] eq[$];
        bit   [25:0] co;
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (iss_ready !== 1'b1) begin
                nerr++;
                $display("FAIL t5_ready_before%0d got=%b exp=1", i, iss_ready);
            end
            iss_valid = 1'b1;
            iss_sign = 1'b0;
            iss_exp = 8'(8'h70 + i);
            iss_special = 2'd0;
            cyc();
        end
        nchk++;
        if (iss_ready !== 1'b0) begin
            nerr++;
            $display("FAIL t5_ready_full got=%b exp=0", iss_ready);
        end
        iss_exp = 8'h11;
        cyc();
        iss_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            co = {1'b1, 25'($urandom)};
            core_done = 1'b1;
            core_out = co;
            core_sticky = 1'b0;
            eq.push_back(ref_pack(0, 8'(8'h70 + i), 2'd0, co, 0));
            cyc();
        end
        core_done = 1'b0;
        nchk++;
        if (iss_ready !== 1'b0 || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL t5_held got rdy=%b v=%b exp rdy=0 v=1", iss_ready, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (out_valid !== 1'b1 || {out_inexact, out_result} !== eq[i]) begin
                nerr++;
                $display("FAIL t5_order%0d got v=%b %h exp %h", i, out_valid,
                         {out_inexact, out_result}, eq[i]);
            end
            cyc();
        end
        out_ready = 1'b0;
        nchk++;
        if (iss_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL t5_restored got rdy=%b v=%b exp rdy=1 v=0", iss_ready, out_valid);
        end
    endtask

    task automatic test_underflow_reset();
        do_reset();
        core_done = 1'b1;
        core_out = 26'h2000000;
        cyc();
        core_done = 1'b0;
        nchk++;
        if (err_underflow !== 1'b1 || out_valid !== 1'b0 || iss_ready !== 1'b1) begin
            nerr++;
            $display("FAIL t6_underflow got u=%b v=%b rdy=%b exp u=1 v=0 rdy=1",
                     err_underflow, out_valid, iss_ready);
        end
        iss_valid = 1'b1;
        iss_special = 2'd0;
        iss_exp = 8'h90;
        cyc();
        cyc();
        iss_valid = 1'b0;
        core_done = 1'b1;
        core_out = 26'h3000003;
        cyc();
        core_done = 1'b0;
        nchk++;
        if (out_valid !== 1'b1 || out_result === 32'h0) begin
            nerr++;
            $display("FAIL t6_prefill got v=%b r=%h exp v=1 r!=0", out_valid, out_result);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        nchk++;
        if ({out_valid, out_result, out_inexact, err_underflow, err_overrun} !== 36'd0
            || iss_ready !== 1'b1) begin
            nerr++;
            $display("FAIL t6_midreset got v=%b r=%h i=%b u=%b o=%b rdy=%b exp zeros rdy=1",
                     out_valid, out_result, out_inexact, err_underflow, err_overrun, iss_ready);
        end
        core_done = 1'b1;
        cyc();
        core_done = 1'b0;
        nchk++;
        if (err_underflow !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL t6_stale_done got u=%b v=%b exp u=1 v=0", err_underflow, out_valid);
        end
        do_reset();
    endtask

    task automatic test_random();
        tag_t        tq[$];
        logic [32:0] eq[$];
        tag_t        t;
        int          infl;
        bit          drain;
        bit          ok;
        bit   [25:0] co;
        bit          st;
        infl = 0;
        for (int c = 0; c < 700; c++) begin
            drain = c >= 600;
            nchk++;
            if (out_valid !== (eq.size() != 0)) begin
                nerr++;
                $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, eq.size() != 0);
            end
            nchk++;
            if (iss_ready !== (infl < 4)) begin
                nerr++;
                $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, iss_ready, infl < 4);
            end
            ok = infl < 4;
            out_ready = drain || ($urandom_range(0, 2) != 0);
            if (out_ready && eq.size() != 0) begin
                nchk++;
                if ({out_inexact, out_result} !== eq[0]) begin
                    nerr++;
                    $display("FAIL rnd_data c=%0d got=%h exp=%h", c,
                             {out_inexact, out_result}, eq[0]);
                end
                void'(eq.pop_front());
                infl--;
            end
            co = {1'b1, 25'($urandom)};
            st = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                co[1:0] = 2'b10;
                st = 1'b0;
            end
            if ($urandom_range(0, 7) == 0)
                co[25:2] = 24'hFFFFFF;
            core_out = co;
            core_sticky = st;
            core_done = (tq.size() != 0) && (drain || $urandom_range(0, 3) != 0);
            if (core_done) begin
                t = tq.pop_front();
                eq.push_back(ref_pack(t.s, t.e, t.sp, co, st));
            end
            iss_valid = !drain && ($urandom_range(0, 1) != 0);
            iss_sign = 1'($urandom);
            iss_exp = ($urandom_range(0, 5) == 0) ? 8'hFE : 8'($urandom_range(0, 254));
            iss_special = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
            if (iss_valid && ok) begin
                t.s = iss_sign;
                t.e = iss_exp;
                t.sp = iss_special;
                tq.push_back(t);
                infl++;
            end
            cyc();
        end
        iss_valid = 1'b0;
        core_done = 1'b0;
        out_ready = 1'b0;
        nchk++;
        if (eq.size() != 0 || tq.size() != 0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rnd_drain left eq=%0d tq=%0d v=%b exp 0/0/0",
                     eq.size(), tq.size(), out_valid);
        end
        nchk++;
        if (err_underflow !== 1'b0 || err_overrun !== 1'b0) begin
            nerr++;
            $display("FAIL rnd_errors got u=%b o=%b exp 0/0", err_underflow, err_overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_tie();
        test_carry();
        test_specials();
        test_credits();
        test_underflow_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
